// File: rtl/pu_riscv_div_unit.sv
// Multi-cycle RV M-extension divider: DIV/DIVU/REM/REMU and RV64 *W forms.
// Ports: clk, rst, flush, start, func, is_w, opA, opB -> busy, done, result.
// Optional: PU_RISCV_DIV_EARLY_OUT_EN skips leading zero dividend bits.
module pu_riscv_div_unit #(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [1:0]      func,
  input  logic            is_w,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam int SH = XLEN - 32;

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_DIV, S_POST, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [1:0]      func_q;
  logic            w_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] dvs, dq, rem;
  logic [CW-1:0]   cnt;
  logic            qneg, rneg;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
    return $signed(x << SH) >>> SH;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] x);
    return (x << SH) >> SH;
  endfunction

`ifdef PU_RISCV_DIV_EARLY_OUT_EN
  function automatic int clz(input logic [XLEN-1:0] x);
    int n;
    n = XLEN;
    for (int i = 0; i < XLEN; i++)
      if (x[i]) n = XLEN - 1 - i;
    return n;
  endfunction
`endif

  // operand preparation, evaluated from latched operands in PREP
  logic            sgn, sa, sb, div0, ovf, special;
  logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, min_n;
  logic [XLEN-1:0] aligned, spec_res;
  int              lz_i, steps_i;

  always_comb begin
    sgn   = ~func_q[0];
    a_ext = w_q ? (sgn ? sext32(a_q) : zext32(a_q)) : a_q;
    b_ext = w_q ? (sgn ? sext32(b_q) : zext32(b_q)) : b_q;
    sa    = sgn & a_ext[XLEN-1];
    sb    = sgn & b_ext[XLEN-1];
    abs_a = sa ? -a_ext : a_ext;
    abs_b = sb ? -b_ext : b_ext;
    min_n = w_q ? ({XLEN{1'b1}} << 31)
                : {1'b1, {(XLEN-1){1'b0}}};
    div0  = (b_ext == '0);
    ovf   = sgn & (a_ext == min_n) & (b_ext == '1);
    // left-align so the N-bit dividend always leaves from bit XLEN-1
    aligned = w_q ? (abs_a << SH) : abs_a;
`ifdef PU_RISCV_DIV_EARLY_OUT_EN
    lz_i    = (clz(aligned) / BITS_PER_CYCLE) * BITS_PER_CYCLE;
    special = div0 | ovf | (abs_a == '0);
`else
    lz_i    = 0;
    special = div0 | ovf;
`endif
    steps_i = ((w_q ? 32 : XLEN) - lz_i) / BITS_PER_CYCLE;
    if (div0)
      spec_res = func_q[1] ? a_ext : '1;
    else if (ovf)
      spec_res = func_q[1] ? '0 : a_ext;
    else
      spec_res = '0;
    spec_res = w_q ? sext32(spec_res) : spec_res;
  end

  // restoring steps retired per DIVIDE cycle
  logic [XLEN:0]   t;
  logic [XLEN-1:0] r_nx, d_nx;

  always_comb begin
    r_nx = rem;
    d_nx = dq;
    t    = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      t    = {r_nx, d_nx[XLEN-1]};
      d_nx = {d_nx[XLEN-2:0], 1'b0};
      if (t >= {1'b0, dvs}) begin
        t       = t - {1'b0, dvs};
        d_nx[0] = 1'b1;
      end
      r_nx = t[XLEN-1:0];
    end
  end

  logic [XLEN-1:0] qv, rv, post_res;

  always_comb begin
    qv       = qneg ? -dq : dq;
    rv       = rneg ? -rem : rem;
    post_res = func_q[1] ? rv : qv;
    post_res = w_q ? sext32(post_res) : post_res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE: if (start) state_nx = S_PREP;
      S_PREP: begin
        busy     = 1'b1;
        state_nx = special ? S_DONE : S_DIV;
      end
      S_DIV: begin
        busy = 1'b1;
        if (cnt == '0) state_nx = S_POST;
      end
      S_POST: begin
        busy     = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      func_q <= '0;
      w_q    <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      dvs    <= '0;
      dq     <= '0;
      rem    <= '0;
      cnt    <= '0;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
      result <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start && !flush) begin
          func_q <= func;
          w_q    <= (XLEN == 64) ? is_w : 1'b0;
          a_q    <= opA;
          b_q    <= opB;
        end
        S_PREP: begin
          dvs  <= abs_b;
          dq   <= aligned << lz_i;
          rem  <= '0;
          cnt  <= CW'(steps_i - 1);
          qneg <= sa ^ sb;
          rneg <= sa;
          if (special && !flush) result <= spec_res;
        end
        S_DIV: begin
          dq  <= d_nx;
          rem <= r_nx;
          cnt <= cnt - 1'b1;
        end
        S_POST: if (!flush) result <= post_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pu_riscv_div_unit.sv
// Self-checking bench for pu_riscv_div_unit (XLEN=64, BITS_PER_CYCLE=2).
// Table vectors, random ops vs. arithmetic model, flush/reset/busy cases.
module tb_pu_riscv_div_unit;

  logic        clk = 1'b0;
  logic        rst, flush, start, is_w;
  logic [1:0]  func;
  logic [63:0] opA, opB;
  logic        busy, done;
  logic [63:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  pu_riscv_div_unit #(.XLEN(64), .BITS_PER_CYCLE(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start),
    .func(func), .is_w(is_w), .opA(opA), .opB(opB),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [1:0] f,
      input bit w, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, q32, r32;
    logic [63:0] q, r;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 0) begin
        q32 = '1; r32 = a32;
      end else if (!f[0] && a32 == 32'h8000_0000 && b32 == '1) begin
        q32 = a32; r32 = 0;
      end else if (!f[0]) begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      q32 = f[1] ? r32 : q32;
      return {{32{q32[31]}}, q32};
    end
    if (b == 0) begin
      q = '1; r = a;
    end else if (!f[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q = a; r = 0;
    end else if (!f[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return f[1] ? r : q;
  endfunction

  function automatic int exp_lat(input logic [1:0] f, input bit w,
      input logic [63:0] a, input logic [63:0] b);
    int          n;
    logic [63:0] an, bn, mag;
    int          sig;
    n   = w ? 32 : 64;
    an  = w ? (f[0] ? {32'h0, a[31:0]} : {{32{a[31]}}, a[31:0]}) : a;
    bn  = w ? {32'h0, b[31:0]} : b;
    if (bn == 0) return 2;
    if (!f[0] && b[n-1 -: 1] == 1'b1 && (w ? b[31:0] == '1 : b == '1)
        && (w ? a[31:0] == 32'h8000_0000
              : a == 64'h8000_0000_0000_0000)) return 2;
    mag = (!f[0] && an[63]) ? -an : an;
    if (w) mag = {32'h0, mag[31:0]};
    sig = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) sig = i + 1;
`ifdef PU_RISCV_DIV_EARLY_OUT_EN
    if (sig == 0) return 2;
    return 3 + (sig + 1) / 2;
`else
    return 3 + n / 2;
`endif
  endfunction

  task automatic do_op(input logic [1:0] f, input bit w,
      input logic [63:0] a, input logic [63:0] b, input bit extra,
      output logic [63:0] res, output int lat);
    func = f; is_w = w; opA = a; opB = b; start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); @(negedge clk);
      start = extra && k >= 3 && k < 6;
      if (extra && k == 3) begin
        opA = 64'd999; opB = 64'd1;
      end
      if (k == 1) check("busy_after_start", {63'h0, busy}, 64'd1);
      if (done) begin
        lat = k;
        break;
      end
    end
    res = result;
    @(negedge clk);
    check("done_pulse_end", {62'h0, done, busy}, 64'd0);
  endtask

  typedef struct {
    logic [1:0]  f;
    bit          w;
    logic [63:0] a, b, exp;
    int          lat;
  } vec_t;

  vec_t        vt[12];
  logic [63:0] res, prev, a, b;
  int          lat, mode, seen;
  logic [1:0]  f;
  bit          w;

  initial begin
    vt[0]  = '{2'b01, 0, 64'd100, 64'd7, 64'd14, 35};
    vt[1]  = '{2'b11, 0, 64'd100, 64'd7, 64'd2, 35};
    vt[2]  = '{2'b00, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
               64'hFFFF_FFFF_FFFF_FFF2, 35};
    vt[3]  = '{2'b10, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
               64'hFFFF_FFFF_FFFF_FFFE, 35};
    vt[4]  = '{2'b00, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2};
    vt[5]  = '{2'b10, 0, 64'd5, 64'd0, 64'd5, 2};
    vt[6]  = '{2'b00, 0, 64'h8000_0000_0000_0000, '1,
               64'h8000_0000_0000_0000, 2};
    vt[7]  = '{2'b10, 0, 64'h8000_0000_0000_0000, '1, 64'd0, 2};
    vt[8]  = '{2'b00, 1, 64'h1_8000_0000, 64'd2,
               64'hFFFF_FFFF_C000_0000, 19};
    vt[9]  = '{2'b01, 1, 64'h1_8000_0000, 64'd2, 64'h4000_0000, 19};
    vt[10] = '{2'b11, 1, 64'h1_8000_0000, 64'd0,
               64'hFFFF_FFFF_8000_0000, 2};
    vt[11] = '{2'b01, 0, 64'd0, 64'd3, 64'd0, 35};

    rst = 1'b1; flush = 1'b0; start = 1'b0; is_w = 1'b0;
    func = 2'b00; opA = '0; opB = '0;
    repeat (2) @(negedge clk);
    check("reset_state", {result[61:0], done, busy}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vt[i]) begin
      do_op(vt[i].f, vt[i].w, vt[i].a, vt[i].b, 1'b0, res, lat);
      check($sformatf("vec%0d_result", i), res, vt[i].exp);
`ifdef PU_RISCV_DIV_EARLY_OUT_EN
      check($sformatf("vec%0d_latency", i), 64'(lat),
            64'(exp_lat(vt[i].f, vt[i].w, vt[i].a, vt[i].b)));
`else
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].lat));
`endif
    end

    for (int i = 0; i < 60; i++) begin
      f    = 2'($urandom_range(0, 3));
      w    = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 5);
      a    = {$urandom, $urandom};
      b    = {$urandom, $urandom};
      unique case (mode)
        1: b = ($urandom_range(0, 1) == 1) ? -64'($urandom_range(1, 20))
                                            : 64'($urandom_range(1, 20));
        2: b = '0;
        3: begin
          a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = '1;
        end
        4: b = 64'($urandom_range(1, 65535));
        5: a = 64'($urandom_range(0, 300));
        default: ;
      endcase
      do_op(f, w, a, b, 1'b0, res, lat);
      check($sformatf("rnd%0d_f%0d_w%0d_result", i, f, w), res,
            ref_res(f, w, a, b));
      check($sformatf("rnd%0d_latency", i), 64'(lat),
            64'(exp_lat(f, w, a, b)));
    end

    do_op(2'b01, 0, 64'd100, 64'd7, 1'b1, res, lat);
    check("start_while_busy_result", res, 64'd14);
    check("start_while_busy_latency", 64'(lat), 64'(exp_lat(2'b01, 0, 64'd100, 64'd7)));

    prev = res;
    func = 2'b01; is_w = 1'b0; opA = 64'd1000; opB = 64'd3;
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_done", {62'h0, done, busy}, 64'd0);
    check("flush_result_held", result, prev);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("flush_no_done", 64'(seen), 64'd0);
    check("result_still_held", result, prev);
    do_op(2'b01, 0, 64'd1000, 64'd3, 1'b0, res, lat);
    check("after_flush_result", res, 64'd333);

    func = 2'b00; opA = 64'd9; opB = 64'd2;
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_beats_start", {62'h0, done, busy}, 64'd0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset_mid_op", {result[61:0], done, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("reset_no_done", 64'(seen), 64'd0);
    do_op(2'b10, 1, 64'hFFFF_FFF9, 64'd3, 1'b0, res, lat);
    check("after_reset_remw", res, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
